// File: rtl/tconv_fifo_ctrl_if.sv
// Handshake and FIFO-control bundle for the transposed-convolution row FIFO
// sequencer. The master side is the sequencer; the slave side is the
// environment (upstream row source, downstream MAC array and the FIFO).
interface tconv_fifo_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_ready;
    logic out_valid;
    logic wr_clr;
    logic rd_clr;
    logic wr_en;
    logic wr_inc;
    logic rd_en;
    logic rd_inc;

    modport master (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid,
        output wr_clr,
        output rd_clr,
        output wr_en,
        output wr_inc,
        output rd_en,
        output rd_inc
    );

    modport slave (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  wr_clr,
        input  rd_clr,
        input  wr_en,
        input  wr_inc,
        input  rd_en,
        input  rd_inc
    );
endinterface

// File: rtl/tconv_fifo_ctrl.sv
// Row FIFO sequencer for transposed convolution: loads one feature-map row of
// ROW_LEN elements, replays it RD_PASSES times (one per kernel row), and
// repeats for NUM_ROWS rows per frame. FIFO strobes are combinational decodes
// of the state and the handshake inputs; out_valid tracks the FIFO's one-cycle
// read latency.
module tconv_fifo_ctrl #(
    parameter int ROW_LEN   = 10,
    parameter int NUM_ROWS  = 4,
    parameter int RD_PASSES = 3,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    tconv_fifo_ctrl_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     row_idx,
    output logic [CNT_W-1:0]     pass_idx
);

    localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(ROW_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(NUM_ROWS - 1);
    localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(RD_PASSES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WCLR  = 3'd1,
        WRITE = 3'd2,
        RCLR  = 3'd3,
        READ  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] elem_cnt_q, elem_cnt_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] pass_q, pass_d;

    // Strobe decodes shared between the FSM and the read-valid register.
    logic wr_en_c;
    logic rd_en_c;
    logic vld_p1;

    // State and counter registers; async reset returns to IDLE with counters cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            elem_cnt_q <= '0;
            row_q      <= '0;
            pass_q     <= '0;
        end else begin
            state_q    <= state_d;
            elem_cnt_q <= elem_cnt_d;
            row_q      <= row_d;
            pass_q     <= pass_d;
        end
    end

    // Next-state, counter updates and FIFO/handshake strobe decode.
    always_comb begin
        state_d      = state_q;
        elem_cnt_d   = elem_cnt_q;
        row_d        = row_q;
        pass_d       = pass_q;
        wr_en_c      = 1'b0;
        rd_en_c      = 1'b0;
        bus.in_ready = 1'b0;
        bus.wr_clr   = 1'b0;
        bus.rd_clr   = 1'b0;
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WCLR;
                end
            end

            WCLR: begin
                // Both pointers restart for a fresh row.
                bus.wr_clr = 1'b1;
                bus.rd_clr = 1'b1;
                elem_cnt_d = '0;
                pass_d     = '0;
                state_d    = WRITE;
            end

            WRITE: begin
                bus.in_ready = 1'b1;
                wr_en_c      = bus.in_valid;
                if (bus.in_valid) begin
                    if (elem_cnt_q == LAST_ELEM) begin
                        elem_cnt_d = '0;
                        state_d    = RCLR;
                    end else begin
                        elem_cnt_d = elem_cnt_q + 1'b1;
                    end
                end
            end

            RCLR: begin
                // Rewind the read pointer before each replay pass.
                bus.rd_clr = 1'b1;
                state_d    = READ;
            end

            READ: begin
                rd_en_c = bus.out_ready;
                if (bus.out_ready) begin
                    if (elem_cnt_q == LAST_ELEM) begin
                        elem_cnt_d = '0;
                        if (pass_q != LAST_PASS) begin
                            pass_d  = pass_q + 1'b1;
                            state_d = RCLR;
                        end else if (row_q != LAST_ROW) begin
                            row_d   = row_q + 1'b1;
                            state_d = WCLR;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        elem_cnt_d = elem_cnt_q + 1'b1;
                    end
                end
            end

            DONE: begin
                done    = 1'b1;
                row_d   = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO read data lands one cycle after rd_en, so valid is delayed to match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_en_c;
        end
    end

    // The FIFO's pointer increments always follow its enables.
    assign bus.wr_en     = wr_en_c;
    assign bus.wr_inc    = wr_en_c;
    assign bus.rd_en     = rd_en_c;
    assign bus.rd_inc    = rd_en_c;
    assign bus.out_valid = vld_p1;

    assign busy     = (state_q != IDLE);
    assign row_idx  = row_q;
    assign pass_idx = pass_q;

    // Sequencer invariants: counters stay in range, write and read never overlap.
    a_elem_range: assert property (@(posedge clk) disable iff (rst) elem_cnt_q <= LAST_ELEM);
    a_row_range:  assert property (@(posedge clk) disable iff (rst) row_q <= LAST_ROW);
    a_pass_range: assert property (@(posedge clk) disable iff (rst) pass_q <= LAST_PASS);
    a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(bus.in_ready && rd_en_c));

endmodule
